cv32e40p_apu_arbiter: RTL and testbench

Shares one FPU wrapper (APU slave) between NUM_REQ core APU master ports. Sits between the cores' APU ports and the FPU instance in a multi-core top. It does round-robin arbitration on the request side. A tag FIFO returns each result to the requester that issued it.

---
 rtl/cv32e40p_apu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_apu_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_core_pkg / cv32e40p_apu_arbiter
//
// Shares one APU slave (FPU wrapper) between NUM_REQ core APU master ports.
// The request side is arbitrated round-robin. A tag FIFO records which
// master was granted each operation, so every result is steered back to the
// master that issued it.
//
// Configuration macro:
//   CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN - when defined, at most one
//   operation is in flight. A new request may still go out in the same cycle
//   that the last outstanding result returns. This keeps out-of-order FPU
//   lanes safe. When undefined, up to TAG_DEPTH operations are in flight and
//   the FPU must complete them in issue order.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_apu_*_i / _o       NUM_REQ master ports: req/gnt, operands, op,
//                          flags, rvalid (one-hot), plus result/rflags
//                          broadcast to all masters
//   apu_*_o / _i           single slave port toward the FPU wrapper
//   outstanding_o          number of tags in flight (0 while in reset)
//   arb_err_o              sticky: a result arrived with no tag in flight
// ---------------------------------------------------------------------------

package cv32e40p_apu_core_pkg;
  parameter int APU_NARGS_CPU    = 3;
  parameter int APU_WOP_CPU      = 6;
  parameter int APU_NDSFLAGS_CPU = 15;
  parameter int APU_NUSFLAGS_CPU = 5;
endpackage

module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  // master ports
  input  logic [NUM_REQ-1:0]                          req_apu_req_i,
  output logic [NUM_REQ-1:0]                          req_apu_gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] req_apu_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         req_apu_op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    req_apu_flags_i,
  output logic [NUM_REQ-1:0]                          req_apu_rvalid_o,
  output logic [31:0]                                 req_apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                 req_apu_rflags_o,
  // slave port
  output logic                                        apu_req_o,
  input  logic                                        apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]              apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                      apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags_o,
  input  logic                                        apu_rvalid_i,
  input  logic [31:0]                                 apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags_i,
  // status
  output logic [$clog2(TAG_DEPTH):0]                  outstanding_o,
  output logic                                        arb_err_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDXP_W = IDX_W + 1;
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Handshake: a request transfers on a cycle where apu_req_o and apu_gnt_i
  // are both 1; that same cycle raises the winner's req_apu_gnt_o bit. A
  // master keeps req and payload stable until it sees its grant. Results
  // carry no ready: apu_rvalid_i is a single-cycle pulse that is always
  // accepted and forwarded as a one-hot req_apu_rvalid_o pulse.

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             arb_err_q;

  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic [IDXP_W-1:0] idx;
  logic             blocked;
  logic             grant;
  logic             pop;
  logic             unmatched;

  // Round-robin search: first request at or above rr_q, wrapping around.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + IDXP_W'(k);
      if (idx >= IDXP_W'(NUM_REQ)) idx = idx - IDXP_W'(NUM_REQ);
      if (!any_req && req_apu_req_i[idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[IDX_W-1:0];
      end
    end
  end

`ifdef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
  // Effective depth of one: a result retiring the only tag frees the slot
  // in the same cycle.
  assign blocked = (count_q != '0) && !(apu_rvalid_i && (count_q == CNT_W'(1)));
`else
  // A pop in the same cycle does not free a slot for a new grant; this keeps
  // the full check off the result path.
  assign blocked = (count_q == CNT_W'(TAG_DEPTH));
`endif

  assign apu_req_o = rst_ni && any_req && !blocked;
  assign grant     = apu_req_o && apu_gnt_i;
  assign pop       = rst_ni && apu_rvalid_i && (count_q != '0);
  assign unmatched = rst_ni && apu_rvalid_i && (count_q == '0);
  assign rr_next   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Slave payload is forced to zero whenever no request is presented.
  assign apu_op_o       = apu_req_o ? req_apu_op_i[winner]       : '0;
  assign apu_flags_o    = apu_req_o ? req_apu_flags_i[winner]    : '0;
  assign apu_operands_o = apu_req_o ? req_apu_operands_i[winner] : '0;

  always_comb begin
    req_apu_gnt_o = '0;
    if (grant) req_apu_gnt_o[winner] = 1'b1;
  end

  always_comb begin
    req_apu_rvalid_o = '0;
    if (pop) req_apu_rvalid_o[tag_mem[rd_ptr_q]] = 1'b1;
  end

  assign req_apu_result_o = apu_rdata_i;
  assign req_apu_rflags_o = apu_rflags_i;
  assign outstanding_o    = rst_ni ? count_q : '0;
  assign arb_err_o        = arb_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      if (grant) begin
        rr_q     <= rr_next;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (unmatched) arb_err_q <= 1'b1;
      case ({grant, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (grant) tag_mem[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for cv32e40p_apu_arbiter (NUM_REQ=2, TAG_DEPTH=4). A behavioural
// model (round-robin pointer as an int, tag queue exp_q) predicts every
// output each cycle; scenario tasks add directed expectations.
// ---------------------------------------------------------------------------

module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int TAG_DEPTH = 4;
  localparam int IDX_W     = 1;
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;
  localparam int VW        = 1 + 2 * NUM_REQ + CNT_W + 1 + APU_WOP_CPU + APU_NDSFLAGS_CPU
                             + APU_NARGS_CPU * 32 + 32 + APU_NUSFLAGS_CPU;
`ifdef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
  localparam bit SINGLE = 1'b1;
`else
  localparam bit SINGLE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_REQ-1:0]                          req_apu_req;
  logic [NUM_REQ-1:0]                          req_apu_gnt;
  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] req_apu_operands;
  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         req_apu_op;
  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    req_apu_flags;
  logic [NUM_REQ-1:0]                          req_apu_rvalid;
  logic [31:0]                                 req_apu_result;
  logic [APU_NUSFLAGS_CPU-1:0]                 req_apu_rflags;
  logic                                        apu_req;
  logic                                        apu_gnt;
  logic [APU_NARGS_CPU-1:0][31:0]              apu_operands;
  logic [APU_WOP_CPU-1:0]                      apu_op;
  logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags;
  logic                                        apu_rvalid;
  logic [31:0]                                 apu_rdata;
  logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags;
  logic [CNT_W-1:0]                            outstanding;
  logic                                        arb_err;

  cv32e40p_apu_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_apu_req_i      (req_apu_req),
    .req_apu_gnt_o      (req_apu_gnt),
    .req_apu_operands_i (req_apu_operands),
    .req_apu_op_i       (req_apu_op),
    .req_apu_flags_i    (req_apu_flags),
    .req_apu_rvalid_o   (req_apu_rvalid),
    .req_apu_result_o   (req_apu_result),
    .req_apu_rflags_o   (req_apu_rflags),
    .apu_req_o          (apu_req),
    .apu_gnt_i          (apu_gnt),
    .apu_operands_o     (apu_operands),
    .apu_op_o           (apu_op),
    .apu_flags_o        (apu_flags),
    .apu_rvalid_i       (apu_rvalid),
    .apu_rdata_i        (apu_rdata),
    .apu_rflags_i       (apu_rflags),
    .outstanding_o      (outstanding),
    .arb_err_o          (arb_err)
  );

  logic [VW-1:0] obs_vec;
  logic [VW-1:0] exp_vec;
  assign obs_vec = {apu_req, req_apu_gnt, req_apu_rvalid, outstanding, arb_err,
                    apu_op, apu_flags, apu_operands, req_apu_result, req_apu_rflags};

  int total = 0;
  int bad   = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [IDX_W-1:0] exp_q[$];   // requester index of each operation in flight
  int               rr_m;
  bit               err_m;
  logic             m_req;
  int               m_win;
  logic [NUM_REQ-1:0] m_gnt;
  logic [NUM_REQ-1:0] m_rvalid;
  logic [NUM_REQ-1:0] last_gnt;

  // FPU model: in-order, fixed latency, due cycle per operation
  int fpu_q[$];
  int cyc = 0;
  bit fpu_on = 0;
  int fpu_lat = 2;

  task automatic model_eval();
    bit any;
    bit blocked;
    logic [APU_WOP_CPU-1:0]            e_op;
    logic [APU_NDSFLAGS_CPU-1:0]       e_flags;
    logic [APU_NARGS_CPU-1:0][31:0]    e_ops;
    logic [CNT_W-1:0]                  e_out;
    any = 0;
    m_win = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (rr_m + k) % NUM_REQ;
      if (!any && req_apu_req[i]) begin
        any = 1;
        m_win = i;
      end
    end
    if (SINGLE) blocked = (exp_q.size() != 0) && !(apu_rvalid && exp_q.size() == 1);
    else        blocked = (exp_q.size() >= TAG_DEPTH);
    m_req = rst_n && any && !blocked;
    m_gnt = '0;
    if (m_req && apu_gnt) m_gnt[m_win] = 1'b1;
    m_rvalid = '0;
    if (rst_n && apu_rvalid && exp_q.size() > 0) m_rvalid[exp_q[0]] = 1'b1;
    e_out = rst_n ? CNT_W'(exp_q.size()) : '0;
    e_op = '0;
    e_flags = '0;
    e_ops = '0;
    if (m_req) begin
      e_op = req_apu_op[m_win];
      e_flags = req_apu_flags[m_win];
      e_ops = req_apu_operands[m_win];
    end
    exp_vec = {m_req, m_gnt, m_rvalid, e_out, err_m, e_op, e_flags, e_ops, apu_rdata, apu_rflags};
  endtask

  task automatic model_commit();
    model_eval();
    if (!rst_n) begin
      rr_m = 0;
      exp_q.delete();
      err_m = 0;
    end else begin
      if (apu_rvalid) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else err_m = 1;
      end
      if (m_req && apu_gnt) begin
        exp_q.push_back(IDX_W'(m_win));
        rr_m = (m_win + 1) % NUM_REQ;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_payload(input int i);
    req_apu_op[i] = APU_WOP_CPU'($urandom());
    req_apu_flags[i] = APU_NDSFLAGS_CPU'($urandom());
    for (int a = 0; a < APU_NARGS_CPU; a++) req_apu_operands[i][a] = $urandom();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    last_gnt = m_gnt;
    if (fpu_on && m_req && apu_gnt) fpu_q.push_back(cyc + fpu_lat);
    cyc++;
    #1;
    apu_rvalid = 1'b0;
    if (fpu_on && fpu_q.size() > 0 && fpu_q[0] == cyc) begin
      apu_rvalid = 1'b1;
      void'(fpu_q.pop_front());
    end
    apu_rdata = $urandom();
    apu_rflags = APU_NUSFLAGS_CPU'($urandom());
  endtask

  task automatic renew_granted();
    for (int i = 0; i < NUM_REQ; i++) if (last_gnt[i]) new_payload(i);
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_apu_req = '0;
    apu_gnt = 1'b0;
    fpu_on = 0;
    fpu_q.delete();
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) new_payload(i);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_apu_req = NUM_REQ'($urandom());
      apu_gnt = 1'b1;
      apu_rvalid = 1'b1;
      settle();
      if ({apu_req, req_apu_gnt, req_apu_rvalid, outstanding} !== '0) begin
        bad++;
        $display("FAIL reset_outputs k=%0d got=%b exp=0", k,
                 {apu_req, req_apu_gnt, req_apu_rvalid, outstanding});
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      total++;
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [NUM_REQ-1:0] hist[$];
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_REQ-1:0] exp_rv;
    do_reset();
    req_apu_req = '1;
    apu_gnt = 1'b1;
    fpu_on = 1;
    fpu_lat = 2;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL alt_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      total++;
`ifndef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      if (req_apu_gnt !== exp_g) begin
        bad++;
        $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, req_apu_gnt, exp_g);
      end
      total++;
      exp_rv = (k >= 2) ? hist[k-2] : '0;
      if (req_apu_rvalid !== exp_rv) begin
        bad++;
        $display("FAIL alt_rvalid k=%0d got=%b exp=%b", k, req_apu_rvalid, exp_rv);
      end
      total++;
      hist.push_back(exp_g);
`endif
      advance();
      renew_granted();
    end
    req_apu_req = '0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL alt_drain k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      total++;
      advance();
    end
  endtask

  task automatic test_join();
    do_reset();
    req_apu_req = 2'b10;
    apu_gnt = 1'b0;
    settle();
    if (obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL join_alone got=%h exp=%h", obs_vec, exp_vec);
    end
    total++;
    advance();
    req_apu_req = 2'b11;
    apu_gnt = 1'b1;
    settle();
    if (req_apu_gnt !== 2'b01) begin
      bad++;
      $display("FAIL join_first got=%b exp=01", req_apu_gnt);
    end
    total++;
    advance();
    renew_granted();
`ifndef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
    settle();
    if (req_apu_gnt !== 2'b10) begin
      bad++;
      $display("FAIL join_second got=%b exp=10", req_apu_gnt);
    end
    total++;
    advance();
`endif
    req_apu_req = '0;
    apu_gnt = 1'b0;
  endtask

`ifndef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
  task automatic test_full();
    do_reset();
    req_apu_req = '1;
    apu_gnt = 1'b1;
    for (int k = 0; k < TAG_DEPTH; k++) begin
      settle();
      if (obs_vec !== exp_vec || apu_req !== 1'b1) begin
        bad++;
        $display("FAIL full_fill k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      total++;
      advance();
      renew_granted();
    end
    settle();
    if ({apu_req, outstanding} !== {1'b0, CNT_W'(TAG_DEPTH)}) begin
      bad++;
      $display("FAIL full_stall got=%b/%0d exp=0/%0d", apu_req, outstanding, TAG_DEPTH);
    end
    total++;
    advance();
    apu_rvalid = 1'b1;
    settle();
    if ({apu_req, req_apu_rvalid} !== {1'b0, 2'b01}) begin
      bad++;
      $display("FAIL full_pop got=%b/%b exp=0/01", apu_req, req_apu_rvalid);
    end
    total++;
    advance();
    settle();
    if ({outstanding, req_apu_gnt} !== {CNT_W'(TAG_DEPTH - 1), 2'b01}) begin
      bad++;
      $display("FAIL full_regrant got=%0d/%b exp=%0d/01", outstanding, req_apu_gnt, TAG_DEPTH - 1);
    end
    total++;
    advance();
    req_apu_req = '0;
  endtask
`endif

  task automatic test_unmatched();
    do_reset();
    apu_rvalid = 1'b1;
    settle();
    if (req_apu_rvalid !== 2'b00 || obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL unmatched_rvalid got=%b exp=00", req_apu_rvalid);
    end
    total++;
    advance();
    for (int k = 0; k < 3; k++) begin
      settle();
      if (arb_err !== 1'b1) begin
        bad++;
        $display("FAIL unmatched_sticky k=%0d got=%b exp=1", k, arb_err);
      end
      total++;
      advance();
    end
    rst_n = 1'b0;
    advance();
    settle();
    if (arb_err !== 1'b0) begin
      bad++;
      $display("FAIL unmatched_clear got=%b exp=0", arb_err);
    end
    total++;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req_apu_req = '1;
    apu_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL rstfl_issue k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      total++;
      advance();
      renew_granted();
    end
    req_apu_req = '0;
    apu_gnt = 1'b0;
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    apu_rvalid = 1'b1;
    settle();
    if ({outstanding, req_apu_rvalid} !== {CNT_W'(0), 2'b00}) begin
      bad++;
      $display("FAIL rstfl_flush got=%0d/%b exp=0/00", outstanding, req_apu_rvalid);
    end
    total++;
    advance();
    req_apu_req = '1;
    apu_gnt = 1'b1;
    settle();
    if ({arb_err, req_apu_gnt} !== {1'b1, 2'b01}) begin
      bad++;
      $display("FAIL rstfl_late got=%b/%b exp=1/01", arb_err, req_apu_gnt);
    end
    total++;
    advance();
    req_apu_req = '0;
  endtask

`ifdef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
  task automatic test_single();
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_REQ-1:0] exp_rv;
    do_reset();
    req_apu_req = '1;
    apu_gnt = 1'b1;
    fpu_on = 1;
    fpu_lat = 3;
    for (int k = 0; k < 15; k++) begin
      settle();
      exp_g = '0;
      if (k % 3 == 0) exp_g = ((k / 3) % 2 == 1) ? 2'b10 : 2'b01;
      exp_rv = '0;
      if (k >= 3 && k % 3 == 0) exp_rv = (((k / 3) - 1) % 2 == 1) ? 2'b10 : 2'b01;
      if ({req_apu_gnt, req_apu_rvalid} !== {exp_g, exp_rv}) begin
        bad++;
        $display("FAIL single_seq k=%0d got=%b/%b exp=%b/%b", k, req_apu_gnt, req_apu_rvalid, exp_g, exp_rv);
      end
      total++;
      advance();
      renew_granted();
    end
    req_apu_req = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    fpu_on = 1;
    fpu_lat = $urandom_range(1, 4);
    last_gnt = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_apu_req[i] || last_gnt[i]) begin
          req_apu_req[i] = ($urandom_range(0, 3) != 0);
          new_payload(i);
        end
      end
      apu_gnt = ($urandom_range(0, 3) != 0);
      if (k % 100 == 99) fpu_lat = $urandom_range(1, 4);
      settle();
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      total++;
      advance();
    end
    req_apu_req = '0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    req_apu_req = '0;
    req_apu_op = '0;
    req_apu_flags = '0;
    req_apu_operands = '0;
    apu_gnt = 1'b0;
    apu_rvalid = 1'b0;
    apu_rdata = '0;
    apu_rflags = '0;
    last_gnt = '0;
    rr_m = 0;
    err_m = 0;
    advance();
    advance();
    test_reset();
    test_alternate();
    test_join();
`ifndef CV32E40P_APU_ARB_SINGLE_OUTSTANDING_EN
    test_full();
`else
    test_single();
`endif
    test_unmatched();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
